// File: rtl/if_id_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : if_id_stall_ctrl
// Purpose  : Fetch PC and IF/ID pipeline register with load-use stall,
//            branch flush, bubble request and saturating event counters.
// Revision : 1.0
// ============================================================================
module if_id_stall_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] imem_instr,
    output logic [31:0] pc,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_instr,
    output logic        IF_ID_valid,
    output logic        ID_EX_bubble,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    localparam logic [15:0] c_cnt_max = 16'hFFFF;
    localparam logic [31:0] c_pc_step = 32'd4;

    logic [31:0] r_pc;
    logic [31:0] r_if_id_pc;
    logic [31:0] r_if_id_instr;
    logic        r_if_id_valid;
    logic [15:0] r_stall_count;
    logic [15:0] r_flush_count;

    logic        w_do_flush;
    logic        w_do_stall;
    logic        w_do_advance;
    logic [31:0] w_pc_plus4;

    // A taken branch overrides a simultaneous stall: the stalled instruction
    // is on the wrong path anyway, so it is squashed rather than held.
    assign w_do_flush   = branch_taken;
    assign w_do_stall   = stall & ~branch_taken;
    assign w_do_advance = ~stall & ~branch_taken;
    assign w_pc_plus4   = r_pc + c_pc_step;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc          <= RESET_PC;
            r_if_id_pc    <= 32'h0000_0000;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
        end else if (w_do_flush) begin
            r_pc          <= branch_target;
            r_if_id_pc    <= r_pc;
            r_if_id_instr <= NOP_INSTR;
            r_if_id_valid <= 1'b0;
        end else if (w_do_advance) begin
            r_pc          <= w_pc_plus4;
            r_if_id_pc    <= r_pc;
            r_if_id_instr <= imem_instr;
            r_if_id_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_count <= 16'h0000;
            r_flush_count <= 16'h0000;
        end else begin
            if (w_do_stall && (r_stall_count != c_cnt_max)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
            if (w_do_flush && (r_flush_count != c_cnt_max)) begin
                r_flush_count <= r_flush_count + 16'd1;
            end
        end
    end

    assign pc           = r_pc;
    assign IF_ID_pc     = r_if_id_pc;
    assign IF_ID_instr  = r_if_id_instr;
    assign IF_ID_valid  = r_if_id_valid;
    assign stall_count  = r_stall_count;
    assign flush_count  = r_flush_count;
    assign ID_EX_bubble = stall | branch_taken | ~r_if_id_valid;

endmodule
`default_nettype wire

// File: tb/tb_if_id_stall_ctrl.sv
`default_nettype none
// Testbench for if_id_stall_ctrl: directed pinned cases plus random stimulus
// compared every cycle against a behavioural pipeline model.
module tb_if_id_stall_ctrl;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_instr;
    logic [31:0] pc;
    logic [31:0] IF_ID_pc;
    logic [31:0] IF_ID_instr;
    logic        IF_ID_valid;
    logic        ID_EX_bubble;
    logic [15:0] stall_count;
    logic [15:0] flush_count;

    int n_cmp  = 0;
    int n_fail = 0;
    bit cmp_en = 0;

    if_id_stall_ctrl #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .imem_instr   (imem_instr),
        .pc           (pc),
        .IF_ID_pc     (IF_ID_pc),
        .IF_ID_instr  (IF_ID_instr),
        .IF_ID_valid  (IF_ID_valid),
        .ID_EX_bubble (ID_EX_bubble),
        .stall_count  (stall_count),
        .flush_count  (flush_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents: a fixed word at 0, a hash elsewhere.
    function automatic logic [31:0] mem_at(input logic [31:0] a);
        if (a == 32'h0000_0000) return 32'h0050_0093;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    assign imem_instr = mem_at(pc);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the pipeline front end described as "which event
    // happened this cycle" applied to plain state variables.
    logic [31:0] m_pc       = RESET_PC;
    logic [31:0] m_ifid_pc  = 32'h0;
    logic [31:0] m_ifid_ins = NOP_INSTR;
    bit          m_valid    = 0;
    int          m_stalls   = 0;
    int          m_flushes  = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc = RESET_PC; m_ifid_pc = 0; m_ifid_ins = NOP_INSTR;
            m_valid = 0; m_stalls = 0; m_flushes = 0;
        end else if (branch_taken) begin
            m_ifid_pc = m_pc; m_ifid_ins = NOP_INSTR; m_valid = 0;
            m_pc = branch_target;
            m_flushes = (m_flushes < 65535) ? m_flushes + 1 : 65535;
        end else if (stall) begin
            m_stalls = (m_stalls < 65535) ? m_stalls + 1 : 65535;
        end else begin
            m_ifid_pc = m_pc; m_ifid_ins = mem_at(m_pc); m_valid = 1;
            m_pc = m_pc + 32'd4;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("pc", pc, m_pc);
            check("if_id_pc", IF_ID_pc, m_ifid_pc);
            check("if_id_instr", IF_ID_instr, m_ifid_ins);
            check("if_id_valid", {31'b0, IF_ID_valid}, {31'b0, m_valid});
            check("bubble", {31'b0, ID_EX_bubble}, {31'b0, (stall | branch_taken | !m_valid)});
            check("stall_count", {16'b0, stall_count}, m_stalls);
            check("flush_count", {16'b0, flush_count}, m_flushes);
        end
    end

    task automatic cyc(input logic s, input logic b, input logic [31:0] t);
        stall = s; branch_taken = b; branch_target = t;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pc"}, pc, RESET_PC);
        check({tag, "_ifid_pc"}, IF_ID_pc, 32'h0);
        check({tag, "_ifid_instr"}, IF_ID_instr, NOP_INSTR);
        check({tag, "_valid"}, {31'b0, IF_ID_valid}, 32'h0);
        check({tag, "_stall_cnt"}, {16'b0, stall_count}, 32'h0);
        check({tag, "_flush_cnt"}, {16'b0, flush_count}, 32'h0);
        check({tag, "_bubble"}, {31'b0, ID_EX_bubble}, 32'h1);
    endtask

    initial begin
        rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("rst");
        cmp_en = 1;
        rst = 1'b1;

        // First fetch after reset
        cyc(0, 0, 0);
        check("first_pc", pc, 32'h4);
        check("first_ifid_pc", IF_ID_pc, 32'h0);
        check("first_instr", IF_ID_instr, 32'h0050_0093);
        check("first_valid", {31'b0, IF_ID_valid}, 32'h1);
        check("first_bubble", {31'b0, ID_EX_bubble}, 32'h0);
        cyc(0, 0, 0);
        check("adv_pc", pc, 32'h8);

        // Two-cycle stall holds IF/ID
        for (int i = 1; i <= 2; i++) begin
            cyc(1, 0, 0);
            check("stall_pc", pc, 32'h8);
            check("stall_ifid_pc", IF_ID_pc, 32'h4);
            check("stall_instr", IF_ID_instr, mem_at(32'h4));
            check("stall_bubble", {31'b0, ID_EX_bubble}, 32'h1);
            check("stall_cnt", {16'b0, stall_count}, i);
        end
        cyc(0, 0, 0);
        check("post_stall_pc", pc, 32'hC);
        check("post_stall_ifid_pc", IF_ID_pc, 32'h8);

        // Branch wins over simultaneous stall
        cyc(1, 1, 32'h100);
        check("flush_pc", pc, 32'h100);
        check("flush_instr", IF_ID_instr, NOP_INSTR);
        check("flush_valid", {31'b0, IF_ID_valid}, 32'h0);
        check("flush_cnt", {16'b0, flush_count}, 32'h1);
        check("flush_stall_cnt", {16'b0, stall_count}, 32'h2);
        check("flush_ifid_pc", IF_ID_pc, 32'hC);

        // PC wrap-around and unaligned target
        cyc(0, 1, 32'hFFFF_FFFC);
        cyc(0, 0, 0);
        check("wrap_pc", pc, 32'h0);
        check("wrap_ifid_pc", IF_ID_pc, 32'hFFFF_FFFC);
        cyc(0, 1, 32'h103);
        check("unaligned_pc", pc, 32'h103);
        check("flush_cnt3", {16'b0, flush_count}, 32'h3);

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            int r;
            logic [31:0] t;
            r = $urandom_range(99);
            t = $urandom;
            if ($urandom_range(3) != 0) t[1:0] = 2'b00;
            cyc(r < 30, (r >= 80), t);
        end

        // Stall counter saturation from a fresh reset
        rst = 1'b0;
        #1;
        rst = 1'b1;
        stall = 1'b1; branch_taken = 1'b0;
        repeat (65534) @(posedge clk);
        #1;
        check("sat_pre", {16'b0, stall_count}, 32'hFFFE);
        check("sat_pc_held", pc, RESET_PC);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("sat_hold", {16'b0, stall_count}, 32'hFFFF);
        end

        // Asynchronous reset in the middle of a stall
        #3;
        rst = 1'b0;
        #1;
        check_reset_vals("async");
        stall = 1'b0;
        #3;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rel_pc", pc, RESET_PC + 32'd4);
        check("rel_ifid_pc", IF_ID_pc, RESET_PC);
        check("rel_valid", {31'b0, IF_ID_valid}, 32'h1);
        repeat (3) cyc(0, 0, 0);

        cmp_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
